// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - multi-cycle instruction fetch stage with valid/ready memory and consumer handshakes
// Optional access-fault reporting is enabled by defining FETCH_ACCESS_FAULT_EN.
module fetch_stage #(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(32'h8000_0000)
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] araddr,
  output logic             arvalid,
  input  logic             arready,
  input  logic [31:0]      rdata,
  input  logic [1:0]       rresp,
  input  logic             rvalid,
  output logic             rready,
  output logic             inst_valid,
  input  logic             inst_ready,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic [31:0]      inst,
  output logic [WIDTH-1:0] inst_pc,
  output logic             fetch_fault
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

  state_t           state;
  logic [WIDTH-1:0] pc;

`ifdef FETCH_ACCESS_FAULT_EN
  logic fault_q;
  assign fetch_fault = fault_q;
`else
  assign fetch_fault = 1'b0;
`endif

  // Handshake outputs are pure state decodes, so they change only on clock edges.
  assign arvalid    = (state == REQ);
  assign rready     = (state == WAIT);
  assign inst_valid = (state == HOLD);
  assign araddr     = pc;

  logic unused_bits;
  assign unused_bits = ^{rresp, redirect_pc[1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      pc      <= RESET_PC;
      inst    <= '0;
      inst_pc <= '0;
`ifdef FETCH_ACCESS_FAULT_EN
      fault_q <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: state <= REQ;
        REQ: begin
          if (arready) state <= WAIT;
        end
        WAIT: begin
          if (rvalid) begin
            inst_pc <= pc;
`ifdef FETCH_ACCESS_FAULT_EN
            // A faulting fetch hands the consumer a zero word so it can trap cleanly.
            if (rresp != 2'b00) begin
              inst    <= '0;
              fault_q <= 1'b1;
            end else begin
              inst    <= rdata;
              fault_q <= 1'b0;
            end
`else
            inst <= rdata;
`endif
            state <= HOLD;
          end
        end
        HOLD: begin
          if (inst_ready) begin
            pc    <= redirect_valid ? {redirect_pc[WIDTH-1:2], 2'b00} : pc + WIDTH'(4);
            state <= REQ;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - scoreboard bench for fetch_stage with randomized bus and consumer timing
module tb_fetch_stage;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] araddr;
  logic        arvalid, arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid, rready;
  logic        inst_valid, inst_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        fetch_fault;

  fetch_stage #(.WIDTH(32), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst(inst), .inst_pc(inst_pc), .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        fault;
  } exp_t;

  int checks = 0;
  int errors = 0;

  logic [31:0] addr_q[$];
  exp_t        exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: sees the inputs that will be sampled at the next rising edge.
  logic        prev_ar_stall = 1'b0, prev_hold_stall = 1'b0;
  logic [31:0] prev_addr, prev_inst, prev_pc;
  logic        prev_fault;
  logic [31:0] cur_pc;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      addr_q.delete();
      exp_q.delete();
      addr_q.push_back(RESET_PC);
      prev_ar_stall   <= 1'b0;
      prev_hold_stall <= 1'b0;
    end else begin
      chk("one_hot_phase", 64'(int'(arvalid) + int'(rready) + int'(inst_valid) <= 1), 64'd1);
      if (prev_ar_stall) begin
        chk("req_arvalid_stable", 64'(arvalid), 64'd1);
        chk("req_araddr_stable", 64'(araddr), 64'(prev_addr));
      end
      if (prev_hold_stall) begin
        chk("hold_valid_stable", 64'(inst_valid), 64'd1);
        chk("hold_inst_stable", 64'(inst), 64'(prev_inst));
        chk("hold_pc_stable", 64'(inst_pc), 64'(prev_pc));
        chk("hold_fault_stable", 64'(fetch_fault), 64'(prev_fault));
      end
      if (arvalid && arready) begin
        if (addr_q.size() == 0) begin
          chk("unexpected_request", 64'(araddr), 64'hDEAD);
        end else begin
          cur_pc = addr_q.pop_front();
          chk("araddr", 64'(araddr), 64'(cur_pc));
        end
      end
      if (rready && rvalid) begin
        e.pc = cur_pc;
`ifdef FETCH_ACCESS_FAULT_EN
        e.fault = (rresp != 2'b00);
        e.inst  = e.fault ? 32'h0 : rdata;
`else
        e.fault = 1'b0;
        e.inst  = rdata;
`endif
        exp_q.push_back(e);
      end
      if (inst_valid && inst_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_inst", 64'(inst), 64'hDEAD);
        end else begin
          e = exp_q.pop_front();
          chk("inst", 64'(inst), 64'(e.inst));
          chk("inst_pc", 64'(inst_pc), 64'(e.pc));
          chk("fetch_fault", 64'(fetch_fault), 64'(e.fault));
          addr_q.push_back(redirect_valid ? (redirect_pc & 32'hFFFF_FFFC) : e.pc + 32'd4);
        end
      end
      prev_ar_stall   <= arvalid && !arready;
      prev_hold_stall <= inst_valid && !inst_ready;
      prev_addr  <= araddr;
      prev_inst  <= inst;
      prev_pc    <= inst_pc;
      prev_fault <= fetch_fault;
    end
  end

  // Runs one fetch to its consumer handshake; inputs change 1 time unit after each rising edge.
  task automatic fetch_one(input int aw, input int rw, input int iw, input logic [31:0] data,
                           input logic [1:0] resp, input logic redir, input logic [31:0] rpc,
                           output int cycles, output int iv_at);
    int ac = 0, rc = 0, ic = 0;
    bit done = 0;
    cycles = 0;
    iv_at  = -1;
    while (!done && cycles < 200) begin
      arready        = 1'b0;
      rvalid         = 1'($urandom);
      rdata          = $urandom;
      rresp          = 2'($urandom);
      inst_ready     = 1'b0;
      redirect_valid = 1'($urandom);
      redirect_pc    = $urandom;
      if (arvalid) begin
        arready = (ac == aw);
        ac++;
      end
      if (rready) begin
        rvalid = (rc == rw);
        if (rvalid) begin
          rdata = data;
          rresp = resp;
        end
        rc++;
      end
      if (inst_valid) begin
        if (iv_at < 0) iv_at = cycles;
        inst_ready = (ic == iw);
        if (inst_ready) begin
          redirect_valid = redir;
          redirect_pc    = rpc;
          done = 1;
        end
        ic++;
      end
      @(posedge clk);
      #1;
      cycles++;
    end
    if (!done) chk("fetch_timeout", 64'(cycles), 64'd0);
    arready = 1'b0; rvalid = 1'b0; inst_ready = 1'b0; redirect_valid = 1'b0;
  endtask

  initial begin
    int cyc, iv;
    rst = 1'b1;
    arready = 0; rvalid = 0; rdata = 0; rresp = 0; inst_ready = 0;
    redirect_valid = 0; redirect_pc = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_arvalid", 64'(arvalid), 64'd0);
    chk("rst_rready", 64'(rready), 64'd0);
    chk("rst_inst_valid", 64'(inst_valid), 64'd0);
    chk("rst_araddr", 64'(araddr), 64'(RESET_PC));
    chk("rst_inst", 64'(inst), 64'd0);
    chk("rst_inst_pc", 64'(inst_pc), 64'd0);
    chk("rst_fault", 64'(fetch_fault), 64'd0);
    rst = 1'b0;

    // Best case from reset release: IDLE, REQ, WAIT, HOLD.
    fetch_one(0, 0, 0, 32'h0000_0413, 2'b00, 1'b0, 32'h0, cyc, iv);
    chk("first_iv_cycle", 64'(iv), 64'd3);
    chk("first_total", 64'(cyc), 64'd4);
    chk("next_arvalid", 64'(arvalid), 64'd1);
    chk("next_araddr", 64'(araddr), 64'h8000_0004);

    // Bus stalls add one cycle each.
    fetch_one(4, 3, 0, 32'h1234_5678, 2'b00, 1'b0, 32'h0, cyc, iv);
    chk("stall_iv_cycle", 64'(iv), 64'd9);
    chk("stall_total", 64'(cyc), 64'd10);

    // Consumer stall with redirect carrying misaligned low bits.
    fetch_one(0, 0, 5, 32'hCAFE_0001, 2'b00, 1'b1, 32'h8000_0103, cyc, iv);
    chk("hold_total", 64'(cyc), 64'd8);
    chk("redirect_araddr", 64'(araddr), 64'h8000_0100);

    // Wrap at the top of the address space.
    fetch_one(1, 0, 0, 32'h0BAD_F00D, 2'b00, 1'b1, 32'hFFFF_FFFF, cyc, iv);
    chk("pre_wrap_araddr", 64'(araddr), 64'hFFFF_FFFC);
    fetch_one(0, 1, 1, 32'h7777_7777, 2'b00, 1'b0, 32'h0, cyc, iv);
    chk("wrap_araddr", 64'(araddr), 64'h0);

    // Faulting response followed by an OKAY one.
    fetch_one(0, 0, 0, 32'hFEED_BEEF, 2'b10, 1'b0, 32'h0, cyc, iv);
    fetch_one(0, 0, 0, 32'h0000_0013, 2'b00, 1'b0, 32'h0, cyc, iv);

    // Reset while waiting for data; a late rvalid must not be captured.
    arready = 1'b1;
    @(posedge clk); #1;
    chk("in_wait", 64'(rready), 64'd1);
    arready = 1'b0; rvalid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_rready", 64'(rready), 64'd0);
    chk("abort_araddr", 64'(araddr), 64'(RESET_PC));
    rst = 1'b0; rvalid = 1'b1; rdata = 32'hBAD0_BAD0;
    @(posedge clk); #1;
    chk("abort_req", 64'(arvalid), 64'd1);
    chk("abort_req_addr", 64'(araddr), 64'(RESET_PC));
    chk("abort_no_hold", 64'(inst_valid), 64'd0);
    fetch_one(0, 0, 0, 32'h0000_0297, 2'b00, 1'b0, 32'h0, cyc, iv);
    chk("post_abort_total", 64'(cyc), 64'd3);

    // Randomized traffic.
    for (int n = 0; n < 40; n++) begin
      int aw, rw, iw;
      aw = $urandom_range(0, 3);
      rw = $urandom_range(0, 3);
      iw = $urandom_range(0, 3);
      fetch_one(aw, rw, iw, $urandom, 2'($urandom_range(0, 3) == 0 ? 2 : 0),
                1'($urandom_range(0, 3) == 0), $urandom, cyc, iv);
      chk("rand_iv_cycle", 64'(iv), 64'(2 + aw + rw));
      chk("rand_total", 64'(cyc), 64'(3 + aw + rw + iw));
    end

    @(negedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
